// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential fetch over a req/ack handshake
// into a DEPTH-entry {pc, instruction} FIFO, with redirect/flush support.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  input  logic                       inst_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fpc_q, fpc_d;
  logic [31:0]     drop_addr_q, drop_addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     pc_mem_q   [DEPTH];

  logic            push_c;
  logic            pop_c;
  logic            we_c;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign push_c = (state_q == REQ) && mem_ack;
  assign pop_c  = (count_q != '0) && inst_ready;

  assign mem_req    = (state_q == REQ) || (state_q == DROP);
  assign mem_addr   = (state_q == DROP) ? drop_addr_q : fpc_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem_q[rd_q];
  assign inst_pc    = pc_mem_q[rd_q];
  assign count      = count_q;

  // Next-state: redirect flush, push/pop bookkeeping and fetch FSM
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    count_d     = count_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    we_c        = 1'b0;
    drop_addr_d = (state_q == REQ) ? fpc_q : drop_addr_q;

    if (redirect) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      fpc_d   = {redirect_pc[31:2], 2'b00};
      unique case (state_q)
        IDLE:    state_d = IDLE;
        REQ:     state_d = mem_ack ? IDLE : DROP;
        DROP:    state_d = mem_ack ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      if (push_c) begin
        we_c  = 1'b1;
        wr_d  = wr_q + PW'(1);
        fpc_d = fpc_q + 32'd4;
      end
      if (pop_c) begin
        rd_d = rd_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
      unique case (state_q)
        IDLE: if (count_d < DEPTH_C) state_d = REQ;
        REQ:  if (mem_ack) state_d = (count_d < DEPTH_C) ? REQ : IDLE;
        DROP: if (mem_ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      fpc_q       <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
    end
  end

  // Queue storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (we_c) begin
      inst_mem_q[wr_q] <= mem_rdata;
      pc_mem_q[wr_q]   <= fpc_q;
    end
  end

endmodule
